// File: rtl/fda_pkg.sv
// fetch_decode_alu shared constants and encodings.
// Field widths, opcode/funct values, control encodings, ALU op codes.
package fda_pkg;

  localparam int OPW   = 6;
  localparam int REGW  = 5;
  localparam int SHW   = 5;
  localparam int FNW   = 6;
  localparam int IMMW  = 16;
  localparam int JW    = 26;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_J     = 6'h02;
  localparam logic [OPW-1:0] OP_JAL   = 6'h03;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_BNE   = 6'h05;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPW-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPW-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPW-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPW-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPW-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;
  localparam logic [OPW-1:0] OP_SPIW  = 6'h3E;
  localparam logic [OPW-1:0] OP_SPIR  = 6'h3F;

  localparam logic [FNW-1:0] FN_SLL  = 6'h00;
  localparam logic [FNW-1:0] FN_SRL  = 6'h02;
  localparam logic [FNW-1:0] FN_SRA  = 6'h03;
  localparam logic [FNW-1:0] FN_JR   = 6'h08;
  localparam logic [FNW-1:0] FN_SYSC = 6'h0C;
  localparam logic [FNW-1:0] FN_ADD  = 6'h20;
  localparam logic [FNW-1:0] FN_ADDU = 6'h21;
  localparam logic [FNW-1:0] FN_SUB  = 6'h22;
  localparam logic [FNW-1:0] FN_SUBU = 6'h23;
  localparam logic [FNW-1:0] FN_AND  = 6'h24;
  localparam logic [FNW-1:0] FN_OR   = 6'h25;
  localparam logic [FNW-1:0] FN_XOR  = 6'h26;
  localparam logic [FNW-1:0] FN_NOR  = 6'h27;
  localparam logic [FNW-1:0] FN_SLT  = 6'h2A;
  localparam logic [FNW-1:0] FN_SLTU = 6'h2B;

  localparam logic [REGW-1:0] LINK_REG = 5'd31;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_RD   = 2'b01,
    MEM_WR   = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_MEM  = 2'b01,
    SRC_LINK = 2'b10,
    SRC_SPI  = 2'b11
  } reg_src_e;

  typedef enum logic [1:0] {
    SPI_IDLE = 2'b00,
    SPI_WR   = 2'b01,
    SPI_RD   = 2'b10
  } spi_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    B_REG   = 2'b00,
    B_ZIMM  = 2'b01,
    B_SIMM  = 2'b10,
    B_SHAMT = 2'b11
  } bsel_e;

  typedef enum logic [2:0] {
    PC_SEQ = 3'd0,
    PC_BEQ = 3'd1,
    PC_BNE = 3'd2,
    PC_JMP = 3'd3,
    PC_JR  = 3'd4
  } pcsel_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/fda_alu.sv
// fetch_decode_alu arithmetic/logic unit, purely combinational.
// Shifts move sh_val (rt data) by b[4:0]; carry is bit 32 of add/sub.
module fda_alu
  import fda_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] sh_val,
  input  logic [15:0] imm,
  output logic [31:0] res,
  output logic        carry,
  output logic        zero
);

  logic [32:0] sum33;
  logic [32:0] dif33;

  assign sum33 = {1'b0, a} + {1'b0, b};
  assign dif33 = {1'b0, a} - {1'b0, b};

  // Operation select; only add/sub report a carry.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    unique case (op)
      ALU_ADD: begin
        res   = sum33[31:0];
        carry = sum33[32];
      end
      ALU_SUB: begin
        res   = dif33[31:0];
        carry = dif33[32];
      end
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NOR:  res = ~(a | b);
      ALU_SLT:  res = {31'h0, $signed(a) < $signed(b)};
      ALU_SLTU: res = {31'h0, a < b};
      ALU_SLL:  res = sh_val << b[4:0];
      ALU_SRL:  res = sh_val >> b[4:0];
      ALU_SRA:  res = $unsigned($signed(sh_val) >>> b[4:0]);
      ALU_LUI:  res = {imm, 16'h0000};
      default:  res = '0;
    endcase
  end

  assign zero = (res == 32'h0);

endmodule

// File: rtl/fetch_decode_alu.sv
// Single-cycle MIPS fetch, decode and ALU slice with PC register.
// Define FDA_SPI_EN to decode opcodes 3E/3F as SPI write/read.
module fetch_decode_alu
  import fda_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic [31:0] pc,
  output logic [4:0]  ra1,
  output logic [4:0]  ra2,
  output logic [4:0]  wa,
  output logic        reg_wen,
  output logic [1:0]  mem_cmd,
  output logic [1:0]  reg_src,
  output logic [1:0]  spi_ctrl,
  output logic [31:0] alu_out,
  output logic        carry_out,
  output logic        is_zero,
  output logic [31:0] link_addr,
  output logic        illegal
);

  logic [OPW-1:0]  opcode;
  logic [REGW-1:0] rs;
  logic [REGW-1:0] rt;
  logic [REGW-1:0] rd;
  logic [SHW-1:0]  shamt;
  logic [FNW-1:0]  funct;
  logic [IMMW-1:0] imm;
  logic [JW-1:0]   jaddr;

  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];
  assign imm    = inst[15:0];
  assign jaddr  = inst[25:0];

  assign ra1 = rs;
  assign ra2 = rt;

  alu_op_e     alu_op;
  bsel_e       bsel;
  pcsel_e      pcsel;
  spi_e        spi;
  logic [31:0] imm_sx;
  logic [31:0] opb;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] next_pc;

  // Main decoder: control fields from opcode and funct.
  always_comb begin
    alu_op  = ALU_ADD;
    bsel    = B_SIMM;
    pcsel   = PC_SEQ;
    spi     = SPI_IDLE;
    wa      = rt;
    reg_wen = 1'b0;
    mem_cmd = MEM_NONE;
    reg_src = SRC_ALU;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        wa      = rd;
        bsel    = B_REG;
        reg_wen = 1'b1;
        unique case (funct)
          FN_SLL: begin
            alu_op = ALU_SLL;
            bsel   = B_SHAMT;
          end
          FN_SRL: begin
            alu_op = ALU_SRL;
            bsel   = B_SHAMT;
          end
          FN_SRA: begin
            alu_op = ALU_SRA;
            bsel   = B_SHAMT;
          end
          FN_JR: begin
            reg_wen = 1'b0;
            pcsel   = PC_JR;
          end
          FN_SYSC:         reg_wen = 1'b0;
          FN_ADD, FN_ADDU: alu_op  = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op  = ALU_SUB;
          FN_AND:          alu_op  = ALU_AND;
          FN_OR:           alu_op  = ALU_OR;
          FN_XOR:          alu_op  = ALU_XOR;
          FN_NOR:          alu_op  = ALU_NOR;
          FN_SLT:          alu_op  = ALU_SLT;
          FN_SLTU:         alu_op  = ALU_SLTU;
          default: begin
            reg_wen = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_J: pcsel = PC_JMP;
      OP_JAL: begin
        pcsel   = PC_JMP;
        wa      = LINK_REG;
        reg_wen = 1'b1;
        reg_src = SRC_LINK;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        bsel   = B_REG;
        pcsel  = PC_BEQ;
      end
      OP_BNE: begin
        alu_op = ALU_SUB;
        bsel   = B_REG;
        pcsel  = PC_BNE;
      end
      OP_ADDI, OP_ADDIU: reg_wen = 1'b1;
      OP_SLTI: begin
        alu_op  = ALU_SLT;
        reg_wen = 1'b1;
      end
      OP_SLTIU: begin
        alu_op  = ALU_SLTU;
        reg_wen = 1'b1;
      end
      OP_ANDI: begin
        alu_op  = ALU_AND;
        bsel    = B_ZIMM;
        reg_wen = 1'b1;
      end
      OP_ORI: begin
        alu_op  = ALU_OR;
        bsel    = B_ZIMM;
        reg_wen = 1'b1;
      end
      OP_XORI: begin
        alu_op  = ALU_XOR;
        bsel    = B_ZIMM;
        reg_wen = 1'b1;
      end
      OP_LUI: begin
        alu_op  = ALU_LUI;
        reg_wen = 1'b1;
      end
      OP_LW: begin
        reg_wen = 1'b1;
        mem_cmd = MEM_RD;
        reg_src = SRC_MEM;
      end
      OP_SW: mem_cmd = MEM_WR;
`ifdef FDA_SPI_EN
      OP_SPIW: spi = SPI_WR;
      OP_SPIR: begin
        spi     = SPI_RD;
        reg_wen = 1'b1;
        reg_src = SRC_SPI;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign spi_ctrl = spi;
  assign imm_sx   = sext16(imm);

  // ALU operand B mux.
  always_comb begin
    opb = rd2;
    unique case (bsel)
      B_REG:   opb = rd2;
      B_ZIMM:  opb = {16'h0000, imm};
      B_SIMM:  opb = imm_sx;
      B_SHAMT: opb = {27'h0, shamt};
      default: opb = rd2;
    endcase
  end

  fda_alu u_alu (
    .op     (alu_op),
    .a      (rd1),
    .b      (opb),
    .sh_val (rd2),
    .imm    (imm),
    .res    (alu_out),
    .carry  (carry_out),
    .zero   (is_zero)
  );

  assign pc_plus4  = pc + 32'd4;
  assign br_tgt    = pc_plus4 + {imm_sx[29:0], 2'b00};
  assign j_tgt     = {pc_plus4[31:28], jaddr, 2'b00};
  assign link_addr = pc_plus4;

  // Next-PC select: branches resolve on the ALU zero flag.
  always_comb begin
    next_pc = pc_plus4;
    unique case (pcsel)
      PC_SEQ: next_pc = pc_plus4;
      PC_BEQ: next_pc = is_zero ? br_tgt : pc_plus4;
      PC_BNE: next_pc = is_zero ? pc_plus4 : br_tgt;
      PC_JMP: next_pc = j_tgt;
      PC_JR:  next_pc = rd1;
      default: next_pc = pc_plus4;
    endcase
  end

  // PC register, forced to RESET_PC while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

endmodule

// File: tb/tb_fetch_decode_alu.sv
// Directed-vector bench for fetch_decode_alu.
// Builds with or without FDA_SPI_EN; SPI expectations follow the macro.
module tb_fetch_decode_alu;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] pc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa;
  logic        reg_wen;
  logic [1:0]  mem_cmd;
  logic [1:0]  reg_src;
  logic [1:0]  spi_ctrl;
  logic [31:0] alu_out;
  logic        carry_out;
  logic        is_zero;
  logic [31:0] link_addr;
  logic        illegal;

  int n_vec;
  int n_err;
  logic [31:0] exp_pc;

  fetch_decode_alu #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .rd1       (rd1),
    .rd2       (rd2),
    .pc        (pc),
    .ra1       (ra1),
    .ra2       (ra2),
    .wa        (wa),
    .reg_wen   (reg_wen),
    .mem_cmd   (mem_cmd),
    .reg_src   (reg_src),
    .spi_ctrl  (spi_ctrl),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .is_zero   (is_zero),
    .link_addr (link_addr),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b);
    inst = i;
    rd1  = a;
    rd2  = b;
    #1;
  endtask

  task automatic step(input logic [31:0] nxt);
    exp_pc = nxt;
    @(posedge clk);
    #1;
    check("pc", pc, exp_pc);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst  = 1'b1;
    inst = 32'h0;
    rd1  = 32'h0;
    rd2  = 32'h0;
    #1;
    check("pc_in_reset", pc, RST_PC);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("pc_released", pc, RST_PC);
    check("nop_wen", {31'h0, reg_wen}, 32'h1);
    check("nop_wa", {27'h0, wa}, 32'h0);
    check("nop_link", link_addr, RST_PC + 32'd4);
    check("nop_ill", {31'h0, illegal}, 32'h0);
    step(RST_PC + 32'd4);
    step(RST_PC + 32'd8);
    step(RST_PC + 32'd12);

    // ADDU r3 = r1 + r2
    apply(32'h0022_1821, 32'hFFFF_FFFF, 32'h1);
    check("addu_out", alu_out, 32'h0);
    check("addu_cy", {31'h0, carry_out}, 32'h1);
    check("addu_z", {31'h0, is_zero}, 32'h1);
    check("addu_wen", {31'h0, reg_wen}, 32'h1);
    check("addu_wa", {27'h0, wa}, 32'd3);
    check("addu_ra1", {27'h0, ra1}, 32'd1);
    check("addu_ra2", {27'h0, ra2},32'd2);
    step(exp_pc + 32'd4);

    // SUB 5 - 7 borrows
    apply(32'h0022_1822, 32'd5, 32'd7);
    check("sub_out", alu_out, 32'hFFFF_FFFE);
    check("sub_cy", {31'h0, carry_out}, 32'h1);
    step(exp_pc + 32'd4);

    apply(32'h0022_182A, 32'hFFFF_FFFF, 32'h1);
    check("slt_out", alu_out, 32'h1);
    check("slt_cy", {31'h0, carry_out}, 32'h0);
    step(exp_pc + 32'd4);

    apply(32'h0022_182B, 32'hFFFF_FFFF, 32'h1);
    check("sltu_out", alu_out, 32'h0);
    check("sltu_z", {31'h0, is_zero}, 32'h1);
    step(exp_pc + 32'd4);

    apply(32'h0002_1903, 32'h0, 32'h8000_0000);
    check("sra_out", alu_out, 32'hF800_0000);
    step(exp_pc + 32'd4);

    // ORI zero-extends its immediate
    apply(32'h3424_8000, 32'h0000_1234, 32'h0);
    check("ori_out", alu_out, 32'h0000_9234);
    check("ori_wa", {27'h0, wa}, 32'd4);
    step(exp_pc + 32'd4);

    // ADDI sign-extends
    apply(32'h2024_FFFF, 32'h0, 32'h0);
    check("addi_out", alu_out, 32'hFFFF_FFFF);
    check("addi_cy", {31'h0, carry_out}, 32'h0);
    step(exp_pc + 32'd4);

    apply(32'h3C04_ABCD, 32'h0, 32'h0);
    check("lui_out", alu_out, 32'hABCD_0000);
    step(exp_pc + 32'd4);

    apply(32'h8C24_0008, 32'h100, 32'h0);
    check("lw_out", alu_out, 32'h108);
    check("lw_mem", {30'h0, mem_cmd}, 32'h1);
    check("lw_src", {30'h0, reg_src}, 32'h1);
    check("lw_wen", {31'h0, reg_wen}, 32'h1);
    step(exp_pc + 32'd4);

    apply(32'hAC24_0008, 32'h100, 32'h0);
    check("sw_mem", {30'h0, mem_cmd}, 32'h2);
    check("sw_wen", {31'h0, reg_wen}, 32'h0);
    step(exp_pc + 32'd4);

    // undecoded funct 01
    apply(32'h0000_0001, 32'h0, 32'h0);
    check("ill_flag", {31'h0, illegal}, 32'h1);
    check("ill_wen", {31'h0, reg_wen}, 32'h0);
    step(exp_pc + 32'd4);

    apply(32'h0000_000C, 32'h0, 32'h0);
    check("sys_ill", {31'h0, illegal}, 32'h0);
    check("sys_wen", {31'h0, reg_wen}, 32'h0);
    step(exp_pc + 32'd4);

    apply(32'hFC24_0000, 32'h0, 32'h0);
`ifdef FDA_SPI_EN
    check("spir_ctrl", {30'h0, spi_ctrl}, 32'h2);
    check("spir_wen", {31'h0, reg_wen}, 32'h1);
    check("spir_src", {30'h0, reg_src}, 32'h3);
    check("spir_wa", {27'h0, wa}, 32'd4);
    check("spir_ill", {31'h0, illegal}, 32'h0);
`else
    check("op3f_ill", {31'h0, illegal}, 32'h1);
    check("op3f_wen", {31'h0, reg_wen}, 32'h0);
    check("op3f_spi", {30'h0, spi_ctrl}, 32'h0);
`endif
    step(exp_pc + 32'd4);

    apply(32'hF824_0000, 32'h0, 32'h0);
`ifdef FDA_SPI_EN
    check("spiw_ctrl", {30'h0, spi_ctrl}, 32'h1);
    check("spiw_wen", {31'h0, reg_wen}, 32'h0);
`else
    check("op3e_ill", {31'h0, illegal}, 32'h1);
    check("op3e_spi", {30'h0, spi_ctrl}, 32'h0);
`endif
    step(exp_pc + 32'd4);

    apply(32'h0020_0008, 32'h0000_0200, 32'h0);
    check("jr_wen", {31'h0, reg_wen}, 32'h0);
    step(32'h0000_0200);

    apply(32'h0800_0040, 32'h0, 32'h0);
    step(32'h0000_0100);

    // BNE back by one word, operands equal: not taken
    apply(32'h1422_FFFF, 32'd5, 32'd5);
    check("bne_wen", {31'h0, reg_wen}, 32'h0);
    step(32'h0000_0104);

    apply(32'h0800_0040, 32'h0, 32'h0);
    step(32'h0000_0100);

    apply(32'h1422_FFFF, 32'd5, 32'd6);
    step(32'h0000_0100);

    apply(32'h1022_0004, 32'd3, 32'd3);
    check("beq_z", {31'h0, is_zero}, 32'h1);
    step(32'h0000_0114);

    apply(32'h0810_0000, 32'h0, 32'h0);
    step(32'h0040_0000);

    apply(32'h0C00_0010, 32'h0, 32'h0);
    check("jal_link", link_addr, 32'h0040_0004);
    check("jal_wa", {27'h0, wa}, 32'd31);
    check("jal_src", {30'h0, reg_src}, 32'h2);
    check("jal_wen", {31'h0, reg_wen}, 32'h1);
    step(32'h0000_0040);

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("pc_async_rst", pc, RST_PC);
    @(posedge clk);
    #1;
    check("pc_rst_hold", pc, RST_PC);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
